// File: rtl/systolic_ctrl_if.sv
// Job-control and array-side signals of the systolic array controller.
// The master side is the host/array environment; the slave side is systolic_ctrl.
interface systolic_ctrl_if #(
  parameter int N   = 4,
  parameter int K_W = 8
);
  logic             start;
  logic [K_W-1:0]   k_len;
  logic             abort;
  logic [N-1:0]     res_valid;
  logic             rd_en;
  logic [K_W-1:0]   rd_addr;
  logic             op_zero;
  logic [N*N-1:0]   init;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, k_len, abort, res_valid,
    input  rd_en, rd_addr, op_zero, init, busy, done, err
  );

  modport slave (
    input  start, k_len, abort, res_valid,
    output rd_en, rd_addr, op_zero, init, busy, done, err
  );
endinterface

// File: rtl/systolic_ctrl.sv
// Sequencer for an N x N systolic array: streams K operand rows, flushes the
// array, counts east-edge results and staggers per-PE init along the wavefront.
module systolic_ctrl #(
  parameter int N   = 4,
  parameter int K_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  systolic_ctrl_if.slave bus
);

  localparam int DL = 2*N - 1;
  localparam int CW = $clog2(N*N + N + 1);
  localparam int FW = $clog2(N + 1);

  localparam logic [K_W-1:0] K_MIN   = K_W'(2*N - 1);
  localparam logic [CW-1:0]  CNT_END = CW'(N*N);
  localparam logic [FW-1:0]  FL_LAST = FW'(N);

  typedef enum logic [1:0] {IDLE, FEED, FLUSH, DRAIN} state_t;

  state_t          state;
  logic [K_W-1:0]  k_q;
  logic [K_W-1:0]  rd_addr;
  logic            rd_en;
  logic            op_zero;
  logic            busy;
  logic            done;
  logic            err;
  logic            ts;
  logic [DL-1:0]   dl;
  logic [CW-1:0]   count;
  logic [FW-1:0]   fl_cnt;
  logic            armed;
  logic [CW-1:0]   pc;
  logic [CW-1:0]   count_nxt;
  logic [N*N-1:0]  init_w;

  always_comb begin
    pc = '0;
    for (int unsigned i = 0; i < N; i++) begin
      pc = pc + CW'(bus.res_valid[i]);
    end
    count_nxt = count + pc;
  end

  // PE(i,j) sits on anti-diagonal i+j, so it taps delay-line stage i+j.
  always_comb begin
    init_w = '0;
    for (int unsigned i = 0; i < N; i++) begin
      for (int unsigned j = 0; j < N; j++) begin
        init_w[i*N + j] = dl[i + j];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      k_q     <= '0;
      rd_en   <= 1'b0;
      rd_addr <= '0;
      op_zero <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      ts      <= 1'b0;
      dl      <= '0;
      count   <= '0;
      fl_cnt  <= '0;
      armed   <= 1'b0;
    end else begin
      // armed blocks a start that arrives on the first edge after reset release.
      armed   <= 1'b1;
      done    <= 1'b0;
      err     <= 1'b0;
      ts      <= 1'b0;
      op_zero <= ~rd_en;
      dl      <= {dl[DL-2:0], ts};

      if (state != IDLE && bus.abort) begin
        state <= IDLE;
        busy  <= 1'b0;
        rd_en <= 1'b0;
        dl    <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (armed && bus.start) begin
              if (bus.k_len >= K_MIN) begin
                state   <= FEED;
                k_q     <= bus.k_len;
                rd_en   <= 1'b1;
                rd_addr <= '0;
                busy    <= 1'b1;
                ts      <= 1'b1;
                count   <= '0;
              end else begin
                err <= 1'b1;
              end
            end
          end
          FEED: begin
            if (rd_addr == k_q - K_W'(1)) begin
              state  <= FLUSH;
              rd_en  <= 1'b0;
              ts     <= 1'b1;
              fl_cnt <= '0;
            end else begin
              rd_addr <= rd_addr + K_W'(1);
            end
          end
          FLUSH: begin
            if (fl_cnt == FL_LAST) begin
              state <= DRAIN;
            end else begin
              fl_cnt <= fl_cnt + FW'(1);
            end
          end
          DRAIN: begin
            count <= count_nxt;
            if (count_nxt >= CNT_END) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.rd_en   = rd_en;
  assign bus.rd_addr = rd_addr;
  assign bus.op_zero = op_zero;
  assign bus.init    = init_w;
  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.err     = err;

endmodule

// File: tb/tb_systolic_ctrl.sv
// Bench for systolic_ctrl: directed jobs plus random traffic, checked every cycle
// against a job-timeline model (phases derived from cycle offset since F0).
module tb_systolic_ctrl;
  localparam int N   = 4;
  localparam int K_W = 8;
  localparam int NN  = N*N;

  logic clk = 1'b0;
  logic rst = 1'b1;

  systolic_ctrl_if #(.N(N), .K_W(K_W)) bus ();
  systolic_ctrl #(.N(N), .K_W(K_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Job-level reference state
  bit active;
  bit armed;
  bit prev_rd_en;
  int f0;
  int kk;
  int drained;
  int done_cyc;
  int err_cyc;
  int exp_addr;
  int tiles[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, obs, exp);
  endtask

  task automatic check_outputs();
    bit             e_rd;
    int             off;
    int             d;
    logic [NN-1:0]  e_init;
    e_rd = 1'b0;
    if (active) begin
      off      = cyc - f0;
      e_rd     = (off < kk);
      exp_addr = (off < kk) ? off : kk - 1;
    end
    e_init = '0;
    foreach (tiles[q]) begin
      d = cyc - tiles[q] - 1;
      if (d >= 0 && d <= 2*N-2) begin
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++)
            if (i + j == d) e_init[i*N + j] = 1'b1;
      end
    end
    check_eq("busy",    32'(bus.busy),    32'(active));
    check_eq("rd_en",   32'(bus.rd_en),   32'(e_rd));
    check_eq("rd_addr", 32'(bus.rd_addr), 32'(exp_addr));
    check_eq("op_zero", 32'(bus.op_zero), 32'(!prev_rd_en));
    check_eq("init",    32'(bus.init),    32'(e_init));
    check_eq("done",    32'(bus.done),    32'(cyc == done_cyc));
    check_eq("err",     32'(bus.err),     32'(cyc == err_cyc));
    prev_rd_en = e_rd;
  endtask

  task automatic step(input bit s, input int k, input bit ab, input logic [N-1:0] rv);
    int off;
    check_outputs();
    bus.start     = s;
    bus.k_len     = K_W'(k);
    bus.abort     = ab;
    bus.res_valid = rv;
    @(posedge clk);
    if (!armed) begin
      armed = 1'b1;
    end else if (active) begin
      off = cyc - f0;
      if (ab) begin
        active = 1'b0;
        tiles.delete();
      end else if (off > kk + N) begin
        drained += $countones(rv);
        if (drained >= NN) begin
          active   = 1'b0;
          done_cyc = cyc + 1;
        end
      end
    end else if (s) begin
      if (k >= 2*N-1) begin
        active  = 1'b1;
        f0      = cyc + 1;
        kk      = k;
        drained = 0;
        tiles.push_back(cyc + 1);
        tiles.push_back(cyc + 1 + k);
      end else begin
        err_cyc = cyc + 1;
      end
    end
    cyc++;
    while (tiles.size() > 0 && tiles[0] + 2*N < cyc) void'(tiles.pop_front());
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    #1;
    active     = 1'b0;
    armed      = 1'b0;
    prev_rd_en = 1'b0;
    exp_addr   = 0;
    done_cyc   = -1;
    err_cyc    = -1;
    tiles.delete();
    check_outputs();
    @(negedge clk);
    cyc++;
    rst = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int t = 0; t < n; t++) step(1'b0, 0, 1'b0, '0);
  endtask

  initial begin
    logic [N-1:0] drain_pat [7];
    drain_pat = '{4'b1111, 4'b0011, 4'b1111, 4'b0001, 4'b1111, 4'b0000, 4'b0001};
    bus.start = 1'b0; bus.k_len = '0; bus.abort = 1'b0; bus.res_valid = '0;
    @(negedge clk);
    apply_reset();

    // start on the first edge after release is ignored
    step(1'b1, 8, 1'b0, '0);
    idle(2);

    // K=8 job; res_valid and start noise during FEED/FLUSH must not count
    step(1'b1, 8, 1'b0, '0);
    for (int t = 0; t < 13; t++) step(1'b1, 9, 1'b0, '1);
    for (int t = 0; t < 7; t++) step(1'b0, 0, 1'b0, drain_pat[t]);
    idle(4);

    // short K rejected
    step(1'b1, 6, 1'b0, '0);
    idle(3);

    // abort in cycle 5 of a job, then a fresh job
    step(1'b1, 8, 1'b0, '0);
    for (int t = 0; t < 4; t++) step(1'b0, 0, 1'b0, '0);
    step(1'b0, 0, 1'b1, '0);
    idle(3);
    step(1'b1, 9, 1'b0, '0);
    for (int t = 0; t < 60 && active; t++) step(1'b0, 0, 1'b0, N'($urandom));
    idle(3);

    // abort coinciding with the final count: no done
    step(1'b1, 7, 1'b0, '0);
    for (int t = 0; t < 7 + N + 1; t++) step(1'b0, 0, 1'b0, '0);
    for (int t = 0; t < 3; t++) step(1'b0, 0, 1'b0, '1);
    step(1'b0, 0, 1'b1, '1);
    idle(3);

    // reset in the middle of DRAIN
    step(1'b1, 7, 1'b0, '0);
    for (int t = 0; t < 7 + N + 1; t++) step(1'b0, 0, 1'b0, '0);
    for (int t = 0; t < 2; t++) step(1'b0, 0, 1'b0, 4'b0101);
    apply_reset();
    idle(4);

    // random traffic
    for (int t = 0; t < 500; t++)
      step(1'($urandom_range(0, 5) == 0), int'($urandom_range(0, 20)),
           1'($urandom_range(0, 60) == 0), N'($urandom));
    idle(30);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
